univ_shift_reg: RTL
===================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register: hold, shift left/right, rotate left/right, parallel load and clear.
//  Adds a counted burst engine: one start request performs N shifts/rotates autonomously, then pulses done.
//  Used for serialisers, pattern generators and shift-based datapaths in COA lab designs.
// PARAMETERS
//  WIDTH  4                     register width in bits (>= 2)
//  CNT_W  $clog2(WIDTH+1)       burst length width (local, derived; not overridable)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  en         in   1      enables the single-step operation selected by mode (idle only)
//  mode       in   3      operation select (see table)
//  din_r      in   1      serial input into bit 0 on shift left
//  din_l      in   1      serial input into bit WIDTH-1 on shift right
//  pdata      in   WIDTH  parallel load data
//  start      in   1      burst request (idle only)
//  burst_len  in   CNT_W  number of burst steps, 0..WIDTH
//  Q          out  WIDTH  register contents
//  sout_l     out  1      Q[WIDTH-1], combinational from Q
//  sout_r     out  1      Q[0], combinational from Q
//  busy       out  1      high while burst steps are pending
//  done       out  1      one-cycle pulse at burst completion
// BEHAVIOUR
//  Reset (rst_n=0, async): Q=0, busy=0, done=0, FSM=IDLE, latched mode/count=0. Reset mid-burst aborts it.
//  Mode table (applied on an edge when IDLE & en & !accepted start, or on each BUSY step):
//   000 hold | 001 SHL: Q<={Q[W-2:0],din_r} | 010 SHR: Q<={din_l,Q[W-1:1]}
//   011 ROL: Q<={Q[W-2:0],Q[W-1]} | 100 ROR: Q<={Q[0],Q[W-1:1]}
//   101 load: Q<=pdata | 110 clear: Q<=0 | 111 reserved = hold
//  IDLE, en=0, no start: Q holds.
//  FSM states IDLE, BUSY.
//  Start acceptance in IDLE: start=1 and mode in {001..100}; burst_len and mode are latched on that edge.
//   Q is not modified on the accept edge, even if en=1.
//  start=1 with another mode: start is ignored and the en path applies normally.
//  IDLE -> BUSY on accept if burst_len>0; busy=1 from the next cycle.
//  Accept with burst_len=0: stay IDLE, Q unchanged, done=1 for the following cycle, busy never rises.
//  BUSY: each edge performs one latched-mode step and decrements the count.
//   For SHL/SHR, din_r/din_l are sampled on every step edge.
//   On the edge performing the last step: -> IDLE, busy=0, done=1 for exactly one cycle.
//  Latency: the final Q is visible burst_len edges after the accept edge; busy is high for burst_len cycles.
//  BUSY ignores en, mode, start, burst_len and pdata. A start during BUSY is dropped, not queued.
//  A new start may be accepted in the same cycle done=1; the new burst latches normally.
//  burst_len>WIDTH is clamped to WIDTH.
//  done is high only in the single cycle after completion and is otherwise 0.
// TESTING
//  WIDTH=4, Q=0000, mode=001, din_r=1, en=1, 4 edges -> Q=0001,0011,0111,1111; sout_l=1 after the 4th edge.
//  load pdata=1010, then mode=100, en=1, 1 edge -> Q=0101; mode=010, din_l=1, 1 edge -> Q=1010.
//  Q=1000, mode=011, start, burst_len=3 -> busy=1 for 3 cycles, Q=0001,0010,0100, done pulses once, busy=0.
//  start with burst_len=0 -> Q unchanged, busy stays 0, done=1 for one cycle.
//  rst_n=0 mid-burst (after step 1 of 3) -> Q=0, busy=0, done=0 immediately (async); the burst is not resumed.
//  start and en toggled during BUSY -> ignored; WIDTH=8 ROR burst_len=8 on 0x81 -> Q=0x81, done once.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register with a counted burst engine.
// Single-step operations (hold, shift, rotate, load, clear) run from the en path
// while idle. A start request instead runs N shifts/rotates autonomously and
// pulses done once the last step has been applied.
module univ_shift_reg #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             din_r,
  input  logic             din_l,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q_next;
  logic [2:0]       lat_mode, lat_mode_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             done_next;
  logic [CNT_W-1:0] len_clamped;
  logic             accept;

  // One register update for the given operation code; reserved codes hold.
  function automatic logic [WIDTH-1:0] apply_mode(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      3'b001:  res = {cur[WIDTH-2:0], sr};
      3'b010:  res = {sl, cur[WIDTH-1:1]};
      3'b011:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b100:  res = {cur[0], cur[WIDTH-1:1]};
      3'b101:  res = ld;
      3'b110:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Bursts longer than the register width are capped at one full revolution.
  assign len_clamped = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;

  // Only shift/rotate codes may launch a burst; other codes leave start ignored.
  assign accept = (state == IDLE) && start && (mode >= 3'd1) && (mode <= 3'd4);

  // Next-state, next-register and done-pulse decode.
  always_comb begin
    state_next    = state;
    q_next        = Q;
    lat_mode_next = lat_mode;
    cnt_next      = cnt;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          lat_mode_next = mode;
          cnt_next      = len_clamped;
          if (len_clamped == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end else if (en) begin
          q_next = apply_mode(mode, Q, din_r, din_l, pdata);
        end
      end
      BUSY: begin
        q_next   = apply_mode(lat_mode, Q, din_r, din_l, pdata);
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      Q        <= '0;
      lat_mode <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      Q        <= q_next;
      lat_mode <= lat_mode_next;
      cnt      <= cnt_next;
      done     <= done_next;
    end
  end

  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];
  assign busy   = (state == BUSY);

endmodule
